// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - two-requester ROM arbiter/sequencer; ROM_ARB_FIXED_PRIO_EN selects fixed priority
module rom_arbiter #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int ROM_DEPTH   = 256,
    parameter int ROM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_error,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  rom_error
);
    localparam int CW = $clog2(ROM_LATENCY + 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(ROM_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  state, state_next;
    logic                    owner;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [CW-1:0]           cnt;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    err_q;
    logic [1:0]              grant;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic                    out_of_range;
    logic                    accept;
`ifndef ROM_ARB_FIXED_PRIO_EN
    logic                    last_grant;
`endif

    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
`ifdef ROM_ARB_FIXED_PRIO_EN
            2'b11:   grant = 2'b01;
`else
            // tie goes to whichever requester was not served last
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
`endif
            default: grant = 2'b00;
        endcase
    end

    assign sel_addr     = grant[1] ? req_addr1 : req_addr0;
    assign out_of_range = {1'b0, sel_addr} >= DEPTH_LIM;
    assign accept       = (state == IDLE) && (grant != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 2'b00;
        rom_en     = 1'b0;
        rsp_valid  = 2'b00;
        case (state)
            IDLE: begin
                req_ready = grant;
                if (accept) state_next = out_of_range ? RESP : ISSUE;
            end
            ISSUE: begin
                rom_en     = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt == CW'(1)) state_next = RESP;
            end
            RESP: begin
                rsp_valid  = owner ? 2'b10 : 2'b01;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner  <= 1'b0;
            addr_q <= '0;
            cnt    <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q <= sel_addr;
                        owner  <= grant[1];
                        if (out_of_range) begin
                            data_q <= '0;
                            err_q  <= 1'b1;
                        end
                    end
                end
                ISSUE: cnt <= CW'(ROM_LATENCY);
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        data_q <= rom_data;
                        err_q  <= rom_error;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef ROM_ARB_FIXED_PRIO_EN
    // reset to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last_grant <= 1'b1;
        else if (accept) last_grant <= grant[1];
    end
`endif

    assign rom_addr  = addr_q;
    assign rsp_data  = data_q;
    assign rsp_error = err_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - directed self-checking bench for rom_arbiter
module tb_rom_arbiter;
    localparam int DW = 16;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    req_valid_a, req_ready_a, rsp_valid_a;
    logic [AW-1:0] req_addr0_a, req_addr1_a, rom_addr_a;
    logic [DW-1:0] rsp_data_a, rom_data_a;
    logic          rsp_error_a, rom_en_a, rom_error_a;

    logic [1:0]    req_valid_b, req_ready_b, rsp_valid_b;
    logic [AW-1:0] req_addr0_b, req_addr1_b, rom_addr_b;
    logic [DW-1:0] rsp_data_b, rom_data_b;
    logic          rsp_error_b, rom_en_b, rom_error_b;

    logic          err_cap, err_noise;
    logic [2:0]    pv = 3'b000;
    logic [AW-1:0] pa0, pa1, pa2;

    int total = 0;
    int passed = 0;

    rom_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROM_DEPTH(128), .ROM_LATENCY(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_addr0(req_addr0_a),
        .req_addr1(req_addr1_a), .req_ready(req_ready_a), .rsp_valid(rsp_valid_a),
        .rsp_data(rsp_data_a), .rsp_error(rsp_error_a), .rom_en(rom_en_a),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a), .rom_error(rom_error_a));

    rom_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROM_DEPTH(256), .ROM_LATENCY(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_addr0(req_addr0_b),
        .req_addr1(req_addr1_b), .req_ready(req_ready_b), .rsp_valid(rsp_valid_b),
        .rsp_data(rsp_data_b), .rsp_error(rsp_error_b), .rom_en(rom_en_b),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b), .rom_error(rom_error_b));

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return (a == 8'h10) ? 16'hBEEF : {~a, a};
    endfunction

    // latency-1 ROM: data for the rom_en cycle appears the next cycle only
    always @(posedge clk) rom_data_a <= rom_en_a ? rom_word(rom_addr_a) : 16'h0BAD;

    // latency-3 ROM: data valid only in the third cycle after rom_en
    always @(posedge clk) begin
        pv  <= {pv[1:0], rom_en_b};
        pa0 <= rom_addr_b;
        pa1 <= pa0;
        pa2 <= pa1;
    end
    assign rom_data_b  = pv[2] ? rom_word(pa2) : 16'h0BAD;
    assign rom_error_b = pv[2] ? err_cap : err_noise;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        total++; if (req_ready_a !== 2'b00) $display("FAIL reset_req_ready: got %b want 00", req_ready_a); else passed++;
        total++; if (rsp_valid_a !== 2'b00) $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid_a); else passed++;
        total++; if (rsp_data_a !== 16'h0) $display("FAIL reset_rsp_data: got %h want 0000", rsp_data_a); else passed++;
        total++; if (rsp_error_a !== 1'b0) $display("FAIL reset_rsp_error: got %b want 0", rsp_error_a); else passed++;
        total++; if (rom_en_a !== 1'b0) $display("FAIL reset_rom_en: got %b want 0", rom_en_a); else passed++;
        total++; if (rom_addr_a !== 8'h0) $display("FAIL reset_rom_addr: got %h want 00", rom_addr_a); else passed++;
        total++; if (rsp_valid_b !== 2'b00 || rom_en_b !== 1'b0) $display("FAIL reset_b_outputs: got rsp_valid %b rom_en %b want 00 0", rsp_valid_b, rom_en_b); else passed++;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid_a = 2'b01; req_addr0_a = 8'h10; #1;
        total++; if (req_ready_a !== 2'b01) $display("FAIL single_ready: got %b want 01", req_ready_a); else passed++;
        @(negedge clk);
        total++; if (rom_en_a !== 1'b1 || rom_addr_a !== 8'h10) $display("FAIL single_issue: got rom_en %b addr %h want 1 10", rom_en_a, rom_addr_a); else passed++;
        total++; if (req_ready_a !== 2'b00) $display("FAIL single_ready_busy: got %b want 00", req_ready_a); else passed++;
        req_valid_a = 2'b00;
        @(negedge clk);
        total++; if (rom_en_a !== 1'b0 || rsp_valid_a !== 2'b00) $display("FAIL single_wait: got rom_en %b rsp_valid %b want 0 00", rom_en_a, rsp_valid_a); else passed++;
        @(negedge clk);
        total++; if (rsp_valid_a !== 2'b01) $display("FAIL single_rsp_valid: got %b want 01", rsp_valid_a); else passed++;
        total++; if (rsp_data_a !== 16'hBEEF || rsp_error_a !== 1'b0) $display("FAIL single_rsp_data: got %h err %b want beef 0", rsp_data_a, rsp_error_a); else passed++;
        @(negedge clk);
        total++; if (rsp_valid_a !== 2'b00 || rsp_data_a !== 16'hBEEF) $display("FAIL single_hold: got valid %b data %h want 00 beef", rsp_valid_a, rsp_data_a); else passed++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp;
        req_valid_a = 2'b11; req_addr0_a = 8'h01; req_addr1_a = 8'h02; #1;
        for (int k = 0; k < 4; k++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
            exp = 2'b01;
`else
            exp = (k % 2 == 1) ? 2'b10 : 2'b01;
`endif
            total++; if (req_ready_a !== exp) $display("FAIL rr_grant_%0d: got %b want %b", k, req_ready_a, exp); else passed++;
            repeat (3) @(negedge clk);
            total++; if (rsp_valid_a !== exp || rsp_data_a !== rom_word(exp[1] ? 8'h02 : 8'h01))
                $display("FAIL rr_rsp_%0d: got valid %b data %h want %b %h", k, rsp_valid_a, rsp_data_a, exp, rom_word(exp[1] ? 8'h02 : 8'h01));
            else passed++;
            @(negedge clk);
            #1;
        end
        req_valid_a = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_out_of_range();
        req_valid_a = 2'b10; req_addr1_a = 8'h80; #1;
        total++; if (req_ready_a !== 2'b10) $display("FAIL oor_ready: got %b want 10", req_ready_a); else passed++;
        @(negedge clk);
        total++; if (rom_en_a !== 1'b0 || rsp_valid_a !== 2'b10) $display("FAIL oor_rsp: got rom_en %b valid %b want 0 10", rom_en_a, rsp_valid_a); else passed++;
        total++; if (rsp_data_a !== 16'h0 || rsp_error_a !== 1'b1) $display("FAIL oor_data: got %h err %b want 0000 1", rsp_data_a, rsp_error_a); else passed++;
        req_valid_a = 2'b00;
        @(negedge clk);
        total++; if (rsp_valid_a !== 2'b00 || rom_en_a !== 1'b0) $display("FAIL oor_after: got valid %b rom_en %b want 00 0", rsp_valid_a, rom_en_a); else passed++;
        req_valid_a = 2'b10; req_addr1_a = 8'h7F; #1;
        @(negedge clk);
        total++; if (rom_en_a !== 1'b1 || rom_addr_a !== 8'h7F) $display("FAIL edge_issue: got rom_en %b addr %h want 1 7f", rom_en_a, rom_addr_a); else passed++;
        req_valid_a = 2'b00;
        repeat (2) @(negedge clk);
        total++; if (rsp_valid_a !== 2'b10 || rsp_data_a !== 16'h807F || rsp_error_a !== 1'b0)
            $display("FAIL edge_rsp: got valid %b data %h err %b want 10 807f 0", rsp_valid_a, rsp_data_a, rsp_error_a);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_rom_error_latency();
        err_cap = 1'b1; err_noise = 1'b0;
        req_valid_b = 2'b01; req_addr0_b = 8'h22; #1;
        total++; if (req_ready_b !== 2'b01) $display("FAIL lat_ready: got %b want 01", req_ready_b); else passed++;
        @(negedge clk);
        total++; if (rom_en_b !== 1'b1) $display("FAIL lat_issue: got %b want 1", rom_en_b); else passed++;
        req_valid_b = 2'b00;
        repeat (3) @(negedge clk);
        total++; if (rsp_valid_b !== 2'b00) $display("FAIL lat_early: got %b want 00", rsp_valid_b); else passed++;
        @(negedge clk);
        total++; if (rsp_valid_b !== 2'b01 || rsp_error_b !== 1'b1 || rsp_data_b !== 16'hDD22)
            $display("FAIL lat_rsp_err: got valid %b err %b data %h want 01 1 dd22", rsp_valid_b, rsp_error_b, rsp_data_b);
        else passed++;
        @(negedge clk);
        err_cap = 1'b0; err_noise = 1'b1;
        req_valid_b = 2'b10; req_addr1_b = 8'hFF; #1;
        @(negedge clk);
        total++; if (rom_en_b !== 1'b1 || rom_addr_b !== 8'hFF) $display("FAIL noise_issue: got rom_en %b addr %h want 1 ff", rom_en_b, rom_addr_b); else passed++;
        req_valid_b = 2'b00;
        repeat (4) @(negedge clk);
        total++; if (rsp_valid_b !== 2'b10 || rsp_error_b !== 1'b0 || rsp_data_b !== 16'h00FF)
            $display("FAIL noise_rsp: got valid %b err %b data %h want 10 0 00ff", rsp_valid_b, rsp_error_b, rsp_data_b);
        else passed++;
        err_noise = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int stale;
        stale = 0;
        req_valid_b = 2'b01; req_addr0_b = 8'h30; #1;
        @(negedge clk);
        req_valid_b = 2'b00;
        @(negedge clk);
        rst_n = 1'b0; #1;
        total++; if (rom_en_b !== 1'b0 || rsp_valid_b !== 2'b00 || req_ready_b !== 2'b00)
            $display("FAIL midrst_outputs: got rom_en %b valid %b ready %b want 0 00 00", rom_en_b, rsp_valid_b, req_ready_b);
        else passed++;
        total++; if (rsp_data_b !== 16'h0) $display("FAIL midrst_data: got %h want 0000", rsp_data_b); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req_valid_b = 2'b11; req_addr0_b = 8'h03; req_addr1_b = 8'h04; #1;
        total++; if (req_ready_b !== 2'b01) $display("FAIL midrst_tie: got %b want 01", req_ready_b); else passed++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid_b = 2'b00;
            if (rsp_valid_b !== 2'b00) stale++;
        end
        total++; if (stale !== 0) $display("FAIL midrst_stale: got %0d early responses want 0", stale); else passed++;
        @(negedge clk);
        total++; if (rsp_valid_b !== 2'b01 || rsp_data_b !== 16'hFC03)
            $display("FAIL midrst_rsp: got valid %b data %h want 01 fc03", rsp_valid_b, rsp_data_b);
        else passed++;
    endtask

    initial begin
        req_valid_a = 2'b00; req_addr0_a = '0; req_addr1_a = '0; rom_error_a = 1'b0;
        req_valid_b = 2'b00; req_addr0_b = '0; req_addr1_b = '0;
        err_cap = 1'b0; err_noise = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_single();
        do_reset();
        test_round_robin();
        test_out_of_range();
        test_rom_error_latency();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-requester arbiter and sequencer for the single-port synchronous instruction/constant ROM. Requester 0 (instruction fetch) and requester 1 (data load) each issue address requests through a valid/ready handshake; the arbiter grants one at a time, range-checks the address, drives the ROM port, waits the configured ROM latency, and returns data plus an error flag to the granted requester. It sits between the core's fetch/load units and the ROM macro.

## Interface
- DATA_WIDTH, 16, ROM word width
- ADDR_WIDTH, 8, request/ROM address width
- ROM_DEPTH, 256, number of valid ROM words; addresses >= ROM_DEPTH are out of range
- ROM_LATENCY, 1, cycles from the rom_en cycle to valid rom_data (>= 1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  2  per-requester request valid
- req_addr0  in  ADDR_WIDTH  requester 0 address
- req_addr1  in  ADDR_WIDTH  requester 1 address
- req_ready  out  2  per-requester accept; request accepted on req_valid[i] & req_ready[i]
- rsp_valid  out  2  one-hot, one-cycle response pulse to the owning requester
- rsp_data  out  DATA_WIDTH  response data, valid while any rsp_valid bit is high
- rsp_error  out  1  response error, valid while any rsp_valid bit is high
- rom_en  out  1  ROM read strobe
- rom_addr  out  ADDR_WIDTH  ROM address
- rom_data  in  DATA_WIDTH  ROM read data
- rom_error  in  1  ROM-reported error (parity etc.), valid with rom_data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready[i] = grant[i] (combinational from req_valid and last_grant). One request accepted per visit.
  - Only one valid: grant it. Both valid: grant the requester not in last_grant (round-robin). None: stay.
  - On accept: latch address and owner id, update last_grant. In-range address -> ISSUE; out-of-range -> RESP with rsp_data = 0, rsp_error = 1, no ROM access.
- ISSUE: rom_en = 1 for exactly one cycle, rom_addr = latched address; load wait counter with ROM_LATENCY. -> WAIT.
- WAIT: counter decrements each cycle; in the cycle it reaches the last count (ROM_LATENCY-th WAIT cycle) capture rom_data and rom_error into response registers. -> RESP.
- RESP: rsp_valid[owner] = 1 for one cycle; rsp_data/rsp_error from response registers. -> IDLE.
- req_ready is 0 in ISSUE, WAIT, RESP. Only one transaction in flight.
- rom_addr holds latched address outside ISSUE (don't-care to the ROM while rom_en = 0); rsp_data holds last value when rsp_valid = 0.
- Range check: address >= ROM_DEPTH is out of range; with ROM_DEPTH = 2^ADDR_WIDTH no address errors.

## Timing
- Reset values: state IDLE, last_grant = 1 (requester 0 wins first tie), req_ready = 0 unless valid in IDLE, rsp_valid = 0, rsp_data = 0, rsp_error = 0, rom_en = 0, rom_addr = 0.
- In-range latency: accept edge at cycle T; ISSUE T+1; WAIT T+2..T+1+ROM_LATENCY; rsp_valid at T+2+ROM_LATENCY. Next accept possible at T+3+ROM_LATENCY.
- Out-of-range latency: accept at T, rsp_valid at T+1, next accept T+2.
- Requester must hold req_valid/addr until accepted; dropping req_valid before accept is allowed (no transaction).
- Reset asserted mid-transaction: immediately returns to IDLE, all outputs to reset values, in-flight response discarded (no rsp_valid).
- rom_error is captured only in the capture cycle; ignored otherwise.

## Configuration
- ROM_ARB_FIXED_PRIO_EN: defined -> fixed priority, requester 0 always wins ties, last_grant unused. Undefined (default) -> round-robin as above.

## Test plan
- Single req: after reset, req_valid = 01, addr0 = 0x10, ROM returns 0xBEEF -> rom_en one cycle with rom_addr = 0x10, rsp_valid = 01, rsp_data = 0xBEEF, rsp_error = 0, 3 cycles after accept (ROM_LATENCY = 1).
- Tie round-robin: both valid continuously, addr0 = 0x01, addr1 = 0x02 -> grants alternate 0,1,0,1; rsp_valid alternates 01,10; one response per 4 cycles. With ROM_ARB_FIXED_PRIO_EN: requester 1 never granted while requester 0 stays valid.
- Out of range: ROM_DEPTH = 128, addr1 = 0x80 -> no rom_en, rsp_valid = 10 next cycle, rsp_data = 0, rsp_error = 1; addr 0x7F -> normal ROM access.
- ROM error and latency: ROM_LATENCY = 3, rom_error = 1 in capture cycle -> rsp_valid 5 cycles after accept, rsp_error = 1; rom_error pulsed outside capture cycle -> rsp_error = 0.
- Reset mid-op: rst_n low during WAIT -> rom_en, rsp_valid, req_ready all 0 immediately; after release, requester 0 wins first tie, no stale response emitted.
